// File: rtl/riscv_isa_pkg.sv
// RISC-V ISA constants shared by the front end.
package riscv_isa_pkg;

    // All-zero word is an illegal opcode, so decode treats it as not valid.
    localparam logic [31:0] INST_PAD = 32'h0000_0000;

endpackage

// File: rtl/uarch_pkg.sv
// Microarchitecture-wide widths and the instruction buffer entry type.
package uarch_pkg;

    localparam int unsigned PIPE_WIDTH    = 2;
    localparam int unsigned CPU_ADDR_BITS = 32;
    localparam int unsigned CPU_INST_BITS = 32;
    localparam int unsigned IBUF_DEPTH    = 8;

    typedef struct packed {
        logic [CPU_ADDR_BITS-1:0] pc;
        logic [CPU_INST_BITS-1:0] inst;
    } ibuf_entry_t;

endpackage

// File: rtl/inst_buffer.sv
// Compacting circular instruction buffer between fetch and 2-wide decode.
module inst_buffer
    import uarch_pkg::*;
    import riscv_isa_pkg::*;
#(
    parameter int unsigned DEPTH = IBUF_DEPTH
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        flush,
    input  logic                                        fetch_in_val,
    input  logic [CPU_ADDR_BITS-1:0]                    fetch_in_pc,
    input  logic [PIPE_WIDTH-1:0][CPU_INST_BITS-1:0]    fetch_in_insts,
    input  logic [PIPE_WIDTH-1:0]                       fetch_in_mask,
    output logic                                        buf_rdy,
    output logic [PIPE_WIDTH-1:0][CPU_ADDR_BITS-1:0]    inst_pcs,
    output logic [PIPE_WIDTH-1:0][CPU_INST_BITS-1:0]    insts,
    output logic                                        fetch_val,
    input  logic                                        decode_rdy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    ibuf_entry_t mem_q [DEPTH];
    ptr_t        head_q, head_d, tail_q, tail_d;
    ptr_t        head_p1, tail_p1;
    cnt_t        count_q, count_d;

    logic        push, pop;
    logic [1:0]  n_push, n_pop;
    ibuf_entry_t slot0_ent, slot1_ent;
    ibuf_entry_t wr_ent0, wr_ent1;
    logic        wr_en0, wr_en1;
    ibuf_entry_t rd_ent0, rd_ent1;

    assign head_p1   = head_q + ptr_t'(1);
    assign tail_p1   = tail_q + ptr_t'(1);

    assign buf_rdy   = !rst && (count_q <= cnt_t'(DEPTH - 2));
    assign fetch_val = !rst && (count_q != '0);
    assign push      = fetch_in_val && buf_rdy;
    assign pop       = fetch_val && decode_rdy;

    // Compaction: a lone slot-1 instruction lands at tail, never leaving a hole.
    always_comb begin
        slot0_ent = '{pc: fetch_in_pc, inst: fetch_in_insts[0]};
        slot1_ent = '{pc: fetch_in_pc + CPU_ADDR_BITS'(4), inst: fetch_in_insts[1]};
        wr_ent0   = fetch_in_mask[0] ? slot0_ent : slot1_ent;
        wr_ent1   = slot1_ent;
        wr_en0    = push && (|fetch_in_mask);
        wr_en1    = push && (&fetch_in_mask);
        n_push    = push ? (2'(fetch_in_mask[0]) + 2'(fetch_in_mask[1])) : 2'd0;
        n_pop     = pop ? ((count_q >= cnt_t'(2)) ? 2'd2 : 2'd1) : 2'd0;
        head_d    = head_q + ptr_t'(n_pop);
        tail_d    = tail_q + ptr_t'(n_push);
        count_d   = count_q + cnt_t'(n_push) - cnt_t'(n_pop);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!flush) begin
            if (wr_en0) mem_q[tail_q]  <= wr_ent0;
            if (wr_en1) mem_q[tail_p1] <= wr_ent1;
        end
    end

    always_comb begin
        rd_ent0  = mem_q[head_q];
        rd_ent1  = mem_q[head_p1];
        inst_pcs = '0;
        insts    = '0;
        if (fetch_val) begin
            inst_pcs[0] = rd_ent0.pc;
            insts[0]    = rd_ent0.inst;
            if (count_q >= cnt_t'(2)) begin
                inst_pcs[1] = rd_ent1.pc;
                insts[1]    = rd_ent1.inst;
            end else begin
                inst_pcs[1] = rd_ent0.pc + CPU_ADDR_BITS'(4);
                insts[1]    = INST_PAD;
            end
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (rst) count_q <= cnt_t'(DEPTH));
    a_push_room:   assert property (@(posedge clk) disable iff (rst) push |-> (count_q <= cnt_t'(DEPTH - 2)));

endmodule
